// File: rtl/hilo_div_seq_if.sv
// hilo_div_seq_if: request, divider and HI/LO bus for hilo_div_seq.
// slave is the divider-sequencer view, master the requester view.
interface hilo_div_seq_if;
  logic        start;
  logic        signed_op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        div_ok;
  logic [31:0] div_hi;
  logic [31:0] div_lo;
  logic        div_control;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        hilo_we;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  modport slave (
    input  start, signed_op, a_in, b_in,
    input  div_ok, div_hi, div_lo,
    input  hilo_we, hi_wdata, lo_wdata,
    output div_control, div_a, div_b,
    output hi, lo, busy, done, div_zero
  );

  modport master (
    output start, signed_op, a_in, b_in,
    output div_ok, div_hi, div_lo,
    output hilo_we, hi_wdata, lo_wdata,
    input  div_control, div_a, div_b,
    input  hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/hilo_div_seq.sv
// hilo_div_seq: sequences an external 32-cycle divider into HI/LO.
// Define HILO_DIV_SIGNED_EN to honour signed_op (DIV); default is DIVU only.
module hilo_div_seq (
  input logic           clk,
  input logic           reset,
  hilo_div_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [5:0]  cnt;
  logic        go;
  logic        zero;
  logic        fin;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] q_fix;
  logic [31:0] r_fix;
  logic [31:0] div_a_q;
  logic [31:0] div_b_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        ctl_q;
  logic        busy_q;
  logic        done_q;
  logic        dz_q;

`ifdef HILO_DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;
  logic sa;
  logic sb;

  // Operand magnitudes in, sign-corrected quotient/remainder out
  always_comb begin
    sa    = bus.signed_op & bus.a_in[31];
    sb    = bus.signed_op & bus.b_in[31];
    mag_a = sa ? (32'd0 - bus.a_in) : bus.a_in;
    mag_b = sb ? (32'd0 - bus.b_in) : bus.b_in;
    q_fix = neg_q ? (32'd0 - bus.div_hi) : bus.div_hi;
    r_fix = neg_r ? (32'd0 - bus.div_lo) : bus.div_lo;
  end

  // Remember result signs for the duration of the division
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (go) begin
      neg_q <= sa ^ sb;
      neg_r <= sa;
    end
  end
`else
  // Unsigned only: operands and results pass straight through
  always_comb begin
    mag_a = bus.a_in;
    mag_b = bus.b_in;
    q_fix = bus.div_hi;
    r_fix = bus.div_lo;
  end
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and one-cycle control strobes
  always_comb begin
    state_nx = state;
    go       = 1'b0;
    zero     = 1'b0;
    fin      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.b_in != 32'd0) begin
            go       = 1'b1;
            state_nx = RUN;
          end else begin
            zero = 1'b1;
          end
        end
      end
      RUN: begin
        if (cnt == 6'd32) state_nx = CAPTURE;
      end
      CAPTURE: begin
        if (bus.div_ok) begin
          fin      = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand, counter, status and HI/LO registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_a_q <= 32'd0;
      div_b_q <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      cnt     <= 6'd0;
      ctl_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= fin;
      dz_q   <= zero;
      if (go) begin
        div_a_q <= mag_a;
        div_b_q <= mag_b;
        cnt     <= 6'd0;
        ctl_q   <= 1'b1;
        busy_q  <= 1'b1;
      end
      if (state == RUN) begin
        cnt <= cnt + 6'd1;
        if (cnt == 6'd32) ctl_q <= 1'b0;
      end
      if (fin) begin
        hi_q   <= r_fix;
        lo_q   <= q_fix;
        busy_q <= 1'b0;
      end else if (bus.hilo_we && state != CAPTURE) begin
        hi_q <= bus.hi_wdata;
        lo_q <= bus.lo_wdata;
      end
    end
  end

  assign bus.div_a       = div_a_q;
  assign bus.div_b       = div_b_q;
  assign bus.div_control = ctl_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_zero    = dz_q;

endmodule

// File: tb/tb_hilo_div_seq.sv
// tb_hilo_div_seq: directed vectors, expected HI/LO queued per request,
// popped and compared by a monitor whenever done is seen.
module tb_hilo_div_seq;

  logic clk = 1'b0;
  logic reset;
  logic ok_en;
  int   checks = 0;
  int   errors = 0;
  int   lat;
  int   dc;
  int   ndone;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  hilo_div_seq_if bus();

  hilo_div_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  assign bus.div_ok = ok_en;
  assign bus.div_hi = (bus.div_b != 32'd0) ?
                      bus.div_a / bus.div_b : 32'd0;
  assign bus.div_lo = (bus.div_b != 32'd0) ?
                      bus.div_a % bus.div_b : 32'd0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: each done pulse consumes one queued expectation
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: hi=%h lo=%h", bus.hi, bus.lo);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({bus.hi, bus.lo} !== e) begin
          errors++;
          $display("FAIL result: got hi=%h lo=%h expected hi=%h lo=%h",
                   bus.hi, bus.lo, e[63:32], e[31:0]);
        end
      end
    end
  end

  // Issue one division; optional hilo_we edge, restart edge, div_ok edge
  task automatic run_div(input logic [31:0] a,
                         input logic [31:0] b,
                         input logic        sg,
                         input logic [31:0] eh,
                         input logic [31:0] el,
                         input int          we_n,
                         input int          rs_n,
                         input int          ok_n,
                         output int         l,
                         output int         d);
    bus.a_in      = a;
    bus.b_in      = b;
    bus.signed_op = sg;
    bus.start     = 1'b1;
    exp_q.push_back({eh, el});
    if (ok_n > 0) ok_en = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    d = int'(bus.div_control);
    l = 0;
    for (int n = 1; n <= 60; n++) begin
      if (n == rs_n) begin
        bus.a_in = 32'd50;
        bus.b_in = 32'd5;
      end
      bus.start   = (n == rs_n);
      bus.hilo_we = (n == we_n);
      if (n == ok_n) ok_en = 1'b1;
      @(posedge clk); #1;
      d += int'(bus.div_control);
      if (bus.done) begin
        l = n;
        break;
      end
    end
    bus.start   = 1'b0;
    bus.hilo_we = 1'b0;
    ok_en       = 1'b1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_hi"}, bus.hi, 32'd0);
    chk({nm, "_lo"}, bus.lo, 32'd0);
    chk({nm, "_div_a"}, bus.div_a, 32'd0);
    chk({nm, "_div_b"}, bus.div_b, 32'd0);
    chk({nm, "_busy"}, 32'(bus.busy), 32'd0);
    chk({nm, "_done"}, 32'(bus.done), 32'd0);
    chk({nm, "_dz"}, 32'(bus.div_zero), 32'd0);
    chk({nm, "_ctl"}, 32'(bus.div_control), 32'd0);
  endtask

  initial begin
    reset         = 1'b0;
    ok_en         = 1'b1;
    bus.start     = 1'b0;
    bus.signed_op = 1'b0;
    bus.a_in      = 32'd0;
    bus.b_in      = 32'd0;
    bus.hilo_we   = 1'b0;
    bus.hi_wdata  = 32'd0;
    bus.lo_wdata  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    run_div(32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 0, 0, 0, lat, dc);
    chk("lat_100_7", lat, 32'd34);
    chk("ctl_cycles_100_7", dc, 32'd33);
    chk("busy_after_done", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(bus.done), 32'd0);

    bus.a_in  = 32'd5;
    bus.b_in  = 32'd0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("dz_pulse", 32'(bus.div_zero), 32'd1);
    chk("dz_busy", 32'(bus.busy), 32'd0);
    chk("dz_ctl", 32'(bus.div_control), 32'd0);
    chk("dz_hi_kept", bus.hi, 32'd2);
    chk("dz_lo_kept", bus.lo, 32'd14);
    @(posedge clk); #1;
    chk("dz_one_cycle", 32'(bus.div_zero), 32'd0);
    chk("dz_stay_idle", 32'(bus.busy), 32'd0);

    bus.hi_wdata = 32'hA;
    bus.lo_wdata = 32'hB;
    run_div(32'd20, 32'd6, 1'b0, 32'd2, 32'd3, 34, 0, 0, lat, dc);
    chk("lat_20_6_we", lat, 32'd34);
    chk("capture_wins_hi", bus.hi, 32'd2);
    chk("capture_wins_lo", bus.lo, 32'd3);
    bus.hilo_we = 1'b1;
    @(posedge clk); #1;
    bus.hilo_we = 1'b0;
    chk("idle_we_hi", bus.hi, 32'hA);
    chk("idle_we_lo", bus.lo, 32'hB);

    run_div(32'd1000, 32'd10, 1'b0, 32'd0, 32'd100, 0, 5, 0, lat, dc);
    chk("lat_restart_ignored", lat, 32'd34);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      ndone += int'(bus.done);
    end
    chk("single_done", ndone, 32'd0);
    chk("restart_idle", 32'(bus.busy), 32'd0);

    run_div(32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 0, 0, 37, lat, dc);
    chk("lat_ok_hold", lat, 32'd37);
    chk("ctl_cycles_ok_hold", dc, 32'd33);

`ifdef HILO_DIV_SIGNED_EN
    run_div(32'hFFFFFFF9, 32'd2, 1'b1,
            32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0, 0, lat, dc);
    chk("lat_m7_2", lat, 32'd34);
    run_div(32'd7, 32'hFFFFFFFE, 1'b1,
            32'd1, 32'hFFFFFFFD, 0, 0, 0, lat, dc);
    chk("lat_7_m2", lat, 32'd34);
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1,
            32'd0, 32'h80000000, 0, 0, 0, lat, dc);
    chk("lat_min_m1", lat, 32'd34);
`else
    run_div(32'hFFFFFFF9, 32'd2, 1'b1,
            32'd1, 32'h7FFFFFFC, 0, 0, 0, lat, dc);
    chk("lat_signed_ignored", lat, 32'd34);
`endif

    bus.a_in      = 32'd123;
    bus.b_in      = 32'd4;
    bus.signed_op = 1'b0;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midrun_busy", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    #1;
    chk_all_zero("midrun_reset");
    #2;
    reset = 1'b1;
    @(posedge clk); #1;
    run_div(32'd9, 32'd3, 1'b0, 32'd0, 32'd3, 0, 0, 0, lat, dc);
    chk("lat_after_reset", lat, 32'd34);
    chk("ctl_after_reset", dc, 32'd33);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
